// File: rtl/uart_rx_param.sv
// Mid-bit sampling UART receiver with parity/framing checks and show-ahead RX FIFO; define
// UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit. Frames that arrive while the FIFO is full are dropped and flagged.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_rx,
  input  logic                          rd_en,
  input  logic                          clear_err,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DATA_W + 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MID_T = CLKS_PER_BIT / 2;
`else
  localparam int MID_T = CLKS_PER_BIT / 2 - 1;
`endif
  localparam logic [CNT_W-1:0] MID_C     = CNT_W'(MID_T);
  localparam logic [CNT_W-1:0] BIT_C     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   FULL_C    = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_e;

  state_e             state_q, state_d;
  logic               meta_q, rxs_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bcnt_q, bcnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               push;
  logic               smp;
  logic [ENT_W-1:0]   entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= serial_rx;
      rxs_q  <= meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds the mid sample and hist_q[1] mid-1 when the decision is taken at mid+1.
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rxs_q};
  end
  assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign smp = rxs_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = S_START;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == MID_C) begin
          cnt_d   = '0;
          state_d = smp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_C) begin
          cnt_d   = '0;
          shreg_d = {smp, shreg_q[DATA_W-1:1]};
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == DATA_LAST) begin
            bcnt_d  = '0;
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_C) begin
          cnt_d   = '0;
          perr_d  = (PARITY_MODE == 2) ? ~(^shreg_q ^ smp) : (^shreg_q ^ smp);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_C) begin
          cnt_d  = '0;
          bcnt_d = bcnt_q + 4'd1;
          if (!smp) ferr_d = 1'b1;
          // Leaving at mid-stop lets the next start edge be caught without slip.
          if (bcnt_q == STOP_LAST) begin
            push    = 1'b1;
            bcnt_d  = '0;
            state_d = smp ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entry = {ferr_d, perr_q, shreg_q};

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   fcnt_q, fcnt_d;
  logic             ovr_q, ovr_d;
  logic             do_push, do_pop, drop, full;
  logic [ENT_W-1:0] head;

  assign full    = (fcnt_q == FULL_C);
  assign do_pop  = rd_en && (fcnt_q != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_comb begin
    fcnt_d = fcnt_q;
    case ({do_push, do_pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    ovr_d = ovr_q;
    if (drop)           ovr_d = 1'b1;
    else if (clear_err) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fcnt_q <= fcnt_d;
      ovr_q  <= ovr_d;
    end
  end

  // Storage is not reset; outputs are gated by occupancy so stale entries never show.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign rx_valid   = (fcnt_q != '0);
  assign rx_data    = rx_valid ? head[DATA_W-1:0] : '0;
  assign parity_err = rx_valid & head[DATA_W];
  assign frame_err  = rx_valid & head[DATA_W+1];
  assign overrun    = ovr_q;
  assign fifo_count = fcnt_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised frame stimulus with a queue-based scoreboard for uart_rx_param.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, serial_rx, rd_en, clear_err;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .serial_rx(serial_rx), .rd_en(rd_en), .clear_err(clear_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  logic exp_ovr;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_rx = b;
    tick(CPB);
  endtask

  // Reference: even parity bit makes XOR(data, pbit) = 0; a frame arriving on a full FIFO is lost.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_v);
    exp_t e;
    logic pbit;
    pbit = (^d) ^ bad_par;
    e.d  = d;
    e.pe = bad_par;
    e.fe = ~stop_v;
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop_v);
  endtask

  task automatic wait_valid(input int max_cyc);
    int k;
    k = 0;
    while (!rx_valid && k < max_cyc) begin
      tick(1);
      k++;
    end
    chk("rx_valid_wait", {31'd0, rx_valid}, 32'd1);
  endtask

  task automatic read_one();
    wait_valid(CPB * 24);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_data"},    {24'd0, rx_data},    32'd0);
    chk({tag, "_rx_valid"},   {31'd0, rx_valid},   32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
    chk({tag, "_overrun"},    {31'd0, overrun},    32'd0);
    chk({tag, "_fifo_count"}, {29'd0, fifo_count}, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rd_en && rx_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got data %0h, expected no entry", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data",       {24'd0, rx_data},    {24'd0, e.d});
          chk("sb_parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          chk("sb_frame_err",  {31'd0, frame_err},  {31'd0, e.fe});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic       bp;
    reset = 1'b0; serial_rx = 1'b1; rd_en = 1'b0; clear_err = 1'b0; exp_ovr = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(4);

    send_frame(8'h06, 1'b0, 1'b1);
    wait_valid(CPB * 2);
    chk("t1_count", {29'd0, fifo_count}, 32'd1);
    read_one();
    chk("t1_valid_after_read", {31'd0, rx_valid}, 32'd0);

    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    read_one();
    read_one();

    send_frame(8'hA5, 1'b0, 1'b0);
    serial_rx = 1'b0;
    tick(3 * CPB);
    serial_rx = 1'b1;
    tick(2 * CPB);
    chk("t3_count_after_break", {29'd0, fifo_count}, 32'd1);
    read_one();
    send_frame(8'h3C, 1'b0, 1'b1);
    read_one();

    for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1);
    tick(CPB);
    chk("t4_count_full", {29'd0, fifo_count}, 32'd4);
    chk("t4_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    for (int i = 0; i < 4; i++) read_one();
    chk("t4_count_drained", {29'd0, fifo_count}, 32'd0);
    chk("t4_overrun_sticky", {31'd0, overrun}, {31'd0, exp_ovr});
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    exp_ovr   = 1'b0;
    chk("t4_overrun_cleared", {31'd0, overrun}, {31'd0, exp_ovr});

    serial_rx = 1'b0;
    tick(4);
    serial_rx = 1'b1;
    tick(2 * CPB);
    chk("t5_glitch_count", {29'd0, fifo_count}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1);
    read_one();

    send_frame(8'h5A, 1'b0, 1'b1);
    wait_valid(CPB * 2);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    reset = 1'b0;
    serial_rx = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    exp_ovr = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(CPB);
    send_frame(8'h0F, 1'b0, 1'b1);
    wait_valid(CPB * 2);
    chk("t6_count", {29'd0, fifo_count}, 32'd1);
    read_one();

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      send_frame(rd, bp, 1'b1);
      if (i % 2 == 1) begin
        read_one();
        read_one();
      end
    end

    tick(4);
    chk("sb_drained", exp_q.size(), 32'd0);
    chk("final_count", {29'd0, fifo_count}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
